// File: rtl/pulse_seq_pkg.sv
// Shared symbol encoding, default pattern and partial-match helper for pulse_seq_detector.
// Combinational helpers only: no latency, no flow control.
// Pure definitions package: no backpressure.
package pulse_seq_pkg;

    localparam logic     SYM_X1          = 1'b0;
    localparam logic     SYM_X2          = 1'b1;
    localparam int       MAX_LEN         = 8;
    localparam logic [2:0] DEFAULT_PATTERN = {SYM_X2, SYM_X2, SYM_X1};

    // Longest k < len such that the newest k history symbols (hist[len-1] newest)
    // spell the first k pattern symbols in arrival order; only filled slots count.
    function automatic logic [3:0] calc_prog(
        input logic [MAX_LEN-1:0] hist,
        input logic [3:0]         fill,
        input logic [MAX_LEN-1:0] pat,
        input int                 len
    );
        logic [3:0] best;
        logic       ok;
        int         idx;
        best = '0;
        for (int k = 1; k < MAX_LEN; k++) begin
            if (k < len && k <= int'(fill)) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_LEN; j++) begin
                    if (j < k) begin
                        idx = len - k + j;
                        if (hist[idx[2:0]] != pat[j]) ok = 1'b0;
                    end
                end
                if (ok) best = 4'(k);
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Synchronises one raw async level and emits a single-cycle pulse on its rising edge.
// Latency: level sampled high at edge k gives sym high between edges k+1 and k+2.
// No backpressure: free-running, sym is never held.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sym
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sym = sync_q & ~prev_q;

endmodule

// File: rtl/pulse_seq_detector.sv
// Matches a programmable LEN-symbol sequence of x1/x2 pulses, with progress and match count.
// Latency: outputs register on the edge that consumes a symbol (2 edges after x is sampled).
// No backpressure: symbols arriving while en=0 are dropped, never queued.
module pulse_seq_detector
    import pulse_seq_pkg::*;
#(
    parameter int             LEN           = 3,
    parameter logic [LEN-1:0] PATTERN       = LEN'(DEFAULT_PATTERN),
    parameter bit             OVERLAP       = 1'b0,
    parameter bit             ILLEGAL_RESET = 1'b1,
    parameter int             CNT_W         = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       x1,
    input  logic                       x2,
    input  logic                       en,
    input  logic                       clr,
    output logic                       z_pulse,
    output logic                       z_level,
    output logic                       err,
    output logic [$clog2(LEN+1)-1:0]   prog,
    output logic [CNT_W-1:0]           match_cnt
);

    localparam int            FW   = $clog2(LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(LEN);

    logic             sym1, sym2, sym_val;
    logic             acc, ill, hit;
    logic [LEN-1:0]   hist_q, hist_d, hist_sh;
    logic [FW-1:0]    fill_q, fill_d, fill_sh, prog_d;
    logic             z_pulse_d, z_level_d, err_d;
    logic [CNT_W-1:0] cnt_d;

    pulse_sync_edge u_sync_x1 (.clk(clk), .rst(rst), .din(x1), .sym(sym1));
    pulse_sync_edge u_sync_x2 (.clk(clk), .rst(rst), .din(x2), .sym(sym2));

    assign acc     = en & (sym1 ^ sym2);
    assign ill     = en & sym1 & sym2;
    assign sym_val = sym2 ? SYM_X2 : SYM_X1;
    // Newest symbol enters at the MSB so a full history reads PATTERN bit-for-bit.
    assign hist_sh = {sym_val, hist_q[LEN-1:1]};
    assign fill_sh = (fill_q == FULL) ? FULL : fill_q + FW'(1);
    assign hit     = (fill_sh == FULL) && (hist_sh == PATTERN);

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        prog_d    = prog;
        z_pulse_d = 1'b0;
        z_level_d = z_level;
        err_d     = 1'b0;
        cnt_d     = match_cnt;

        if (ill) begin
            err_d = 1'b1;
            if (ILLEGAL_RESET) begin
                hist_d    = '0;
                fill_d    = '0;
                prog_d    = '0;
                z_level_d = 1'b0;
            end
        end else if (acc) begin
            z_pulse_d = hit;
            z_level_d = hit;
            if (hit && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
                prog_d = '0;
            end else begin
                hist_d = hist_sh;
                fill_d = fill_sh;
                prog_d = FW'(calc_prog(MAX_LEN'(hist_sh), 4'(fill_sh),
                                       MAX_LEN'(PATTERN), LEN));
            end
            if (hit && match_cnt != '1) cnt_d = match_cnt + CNT_W'(1);
        end

        if (clr) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            prog      <= '0;
            z_pulse   <= 1'b0;
            z_level   <= 1'b0;
            err       <= 1'b0;
            match_cnt <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            prog      <= prog_d;
            z_pulse   <= z_pulse_d;
            z_level   <= z_level_d;
            err       <= err_d;
            match_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pulse_seq_detector.sv
// Bench for pulse_seq_detector: six parameter sets share one stimulus stream.
// Directed table rows plus a random phase, all compared against a symbol-list reference model.
module tb_pulse_seq_detector;

    localparam int NI = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x1 = 1'b0, x2 = 1'b0, en = 1'b1, clr = 1'b0;

    always #5 clk = ~clk;

    logic       zp_w [NI];
    logic       zl_w [NI];
    logic       er_w [NI];
    logic [1:0] p0, p1, p2, p3, p4;
    logic [2:0] p5;
    logic [7:0] c0, c1, c2, c3, c5;
    logic [1:0] c4;
    int         act_prog [NI];
    int         act_cnt  [NI];

    pulse_seq_detector u0 (.clk(clk), .rst(rst), .x1(x1), .x2(x2), .en(en), .clr(clr),
        .z_pulse(zp_w[0]), .z_level(zl_w[0]), .err(er_w[0]), .prog(p0), .match_cnt(c0));
    pulse_seq_detector #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)) u1 (.clk(clk), .rst(rst),
        .x1(x1), .x2(x2), .en(en), .clr(clr),
        .z_pulse(zp_w[1]), .z_level(zl_w[1]), .err(er_w[1]), .prog(p1), .match_cnt(c1));
    pulse_seq_detector #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1'b0)) u2 (.clk(clk), .rst(rst),
        .x1(x1), .x2(x2), .en(en), .clr(clr),
        .z_pulse(zp_w[2]), .z_level(zl_w[2]), .err(er_w[2]), .prog(p2), .match_cnt(c2));
    pulse_seq_detector #(.ILLEGAL_RESET(1'b0)) u3 (.clk(clk), .rst(rst),
        .x1(x1), .x2(x2), .en(en), .clr(clr),
        .z_pulse(zp_w[3]), .z_level(zl_w[3]), .err(er_w[3]), .prog(p3), .match_cnt(c3));
    pulse_seq_detector #(.CNT_W(2)) u4 (.clk(clk), .rst(rst),
        .x1(x1), .x2(x2), .en(en), .clr(clr),
        .z_pulse(zp_w[4]), .z_level(zl_w[4]), .err(er_w[4]), .prog(p4), .match_cnt(c4));
    pulse_seq_detector #(.LEN(4), .PATTERN(4'b0110), .OVERLAP(1'b1), .ILLEGAL_RESET(1'b0)) u5 (
        .clk(clk), .rst(rst), .x1(x1), .x2(x2), .en(en), .clr(clr),
        .z_pulse(zp_w[5]), .z_level(zl_w[5]), .err(er_w[5]), .prog(p5), .match_cnt(c5));

    always_comb begin
        act_prog[0] = int'(p0); act_prog[1] = int'(p1); act_prog[2] = int'(p2);
        act_prog[3] = int'(p3); act_prog[4] = int'(p4); act_prog[5] = int'(p5);
        act_cnt[0]  = int'(c0); act_cnt[1]  = int'(c1); act_cnt[2]  = int'(c2);
        act_cnt[3]  = int'(c3); act_cnt[4]  = int'(c4); act_cnt[5]  = int'(c5);
    end

    // Parameter sets of u0..u5, as the reference model sees them.
    int cfg_len  [NI] = '{3, 2, 2, 3, 3, 4};
    int cfg_pat  [NI] = '{6, 3, 3, 6, 6, 6};
    int cfg_ov   [NI] = '{0, 1, 0, 0, 0, 1};
    int cfg_ir   [NI] = '{1, 1, 1, 0, 1, 0};
    int cfg_cntw [NI] = '{8, 8, 8, 8, 2, 8};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    // Reference model: raw samples per channel, and the list of accepted symbols per instance.
    bit h1[$];
    bit h2[$];
    bit sbuf [NI][64];
    int nsym [NI];
    int m_zp [NI], m_zl [NI], m_err [NI], m_prog [NI], m_cnt [NI];

    function automatic bit qget(input bit q[$], input int d);
        if (q.size() >= d) return q[q.size() - d];
        return 1'b0;
    endfunction

    function automatic bit tail_is_head(input int i, input int k);
        for (int j = 0; j < k; j++)
            if (sbuf[i][(nsym[i] - k + j) % 64] != cfg_pat[i][j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit s1, s2, hit;
        // A rising edge sampled two edges ago is consumed now.
        s1 = qget(h1, 2) & ~qget(h1, 3);
        s2 = qget(h2, 2) & ~qget(h2, 3);
        if (rst) begin
            h1.delete();
            h2.delete();
            for (int i = 0; i < NI; i++) begin
                nsym[i] = 0; m_zp[i] = 0; m_zl[i] = 0; m_err[i] = 0; m_prog[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            h1.push_back(x1);
            h2.push_back(x2);
            if (h1.size() > 4) void'(h1.pop_front());
            if (h2.size() > 4) void'(h2.pop_front());
            for (int i = 0; i < NI; i++) begin
                m_zp[i]  = 0;
                m_err[i] = 0;
                if (en && s1 && s2) begin
                    m_err[i] = 1;
                    if (cfg_ir[i] != 0) begin
                        nsym[i] = 0; m_prog[i] = 0; m_zl[i] = 0;
                    end
                end else if (en && (s1 != s2)) begin
                    sbuf[i][nsym[i] % 64] = s2;
                    nsym[i]++;
                    hit = (nsym[i] >= cfg_len[i]) && tail_is_head(i, cfg_len[i]);
                    m_zp[i] = int'(hit);
                    m_zl[i] = int'(hit);
                    if (hit && m_cnt[i] < (1 << cfg_cntw[i]) - 1) m_cnt[i]++;
                    if (hit && cfg_ov[i] == 0) nsym[i] = 0;
                    m_prog[i] = 0;
                    for (int k = 1; k < cfg_len[i]; k++)
                        if (k <= nsym[i] && tail_is_head(i, k)) m_prog[i] = k;
                end
                if (clr) m_cnt[i] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("model z_pulse", i, int'(zp_w[i]), m_zp[i]);
            chk("model z_level", i, int'(zl_w[i]), m_zl[i]);
            chk("model err", i, int'(er_w[i]), m_err[i]);
            chk("model prog", i, act_prog[i], m_prog[i]);
            chk("model match_cnt", i, act_cnt[i], m_cnt[i]);
        end
    end

    // Directed rows: kind 0 check only, 1 x1, 2 x2, 3 x1&x2, 4 one-cycle rst, 5 long reset.
    typedef struct {
        int kind; int inst; int zp; int zl; int er; int pg; int cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input int kind, input int inst, input int zp, input int zl,
                                input int er, input int pg, input int cnt);
        vec_t v;
        v.kind = kind; v.inst = inst; v.zp = zp; v.zl = zl; v.er = er; v.pg = pg; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic pulse(input bit a, input bit b);
        @(negedge clk); x1 = a; x2 = b;
        @(negedge clk); x1 = 1'b0; x2 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic check_row(input vec_t v);
        chk("row z_pulse", v.inst, int'(zp_w[v.inst]), v.zp);
        chk("row z_level", v.inst, int'(zl_w[v.inst]), v.zl);
        chk("row err", v.inst, int'(er_w[v.inst]), v.er);
        chk("row prog", v.inst, act_prog[v.inst], v.pg);
        chk("row match_cnt", v.inst, act_cnt[v.inst], v.cnt);
    endtask

    initial begin
        // x1,x2,x1,x2,x2 on defaults; same stream matches on the no-illegal-reset set
        add(5, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0); add(2, 0, 0, 0, 0, 2, 0); add(1, 0, 0, 0, 0, 1, 0);
        add(2, 0, 0, 0, 0, 2, 0); add(2, 0, 1, 1, 0, 0, 1); add(0, 3, 1, 1, 0, 0, 1);
        // x1,x2,(x1&x2),x2: illegal clears u0 but is ignored by u3
        add(5, 3, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0); add(2, 0, 0, 0, 0, 2, 0); add(3, 0, 0, 0, 1, 0, 0);
        add(0, 3, 0, 0, 1, 2, 0); add(2, 0, 0, 0, 0, 0, 0); add(0, 3, 1, 1, 0, 0, 1);
        // x2,x2,x2 on LEN=2 pattern x2,x2: overlap (u1) vs cleared (u2)
        add(5, 1, 0, 0, 0, 0, 0);
        add(2, 1, 0, 0, 0, 1, 0); add(2, 1, 1, 1, 0, 1, 1); add(0, 2, 1, 1, 0, 0, 1);
        add(2, 1, 1, 1, 0, 1, 2); add(0, 2, 0, 0, 0, 1, 1);
        // rst in the middle of a sequence loses the partial match
        add(5, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0); add(2, 0, 0, 0, 0, 2, 0); add(4, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0, 0, 0);

        foreach (tbl[r]) begin
            case (tbl[r].kind)
                1: pulse(1'b1, 1'b0);
                2: pulse(1'b0, 1'b1);
                3: pulse(1'b1, 1'b1);
                4: begin @(negedge clk); rst = 1'b1; @(posedge clk); #1; end
                5: begin @(negedge clk); rst = 1'b1; repeat (3) @(posedge clk); #1; end
                default: ;
            endcase
            check_row(tbl[r]);
            if (tbl[r].kind >= 4) begin @(negedge clk); rst = 1'b0; end
        end

        // Widely spaced x1,x2,x2: exact z_pulse timing and z_level hold
        do_reset();
        pulse(1'b1, 1'b0); repeat (10) @(negedge clk);
        pulse(1'b0, 1'b1); repeat (10) @(negedge clk);
        x2 = 1'b1;
        @(posedge clk); #1; chk("spaced z_pulse edge k", 0, int'(zp_w[0]), 0);
        @(negedge clk); x2 = 1'b0;
        @(posedge clk); #1; chk("spaced z_pulse edge k+1", 0, int'(zp_w[0]), 0);
        @(posedge clk); #1; chk("spaced z_pulse edge k+2", 0, int'(zp_w[0]), 1);
        chk("spaced z_level", 0, int'(zl_w[0]), 1);
        chk("spaced match_cnt", 0, act_cnt[0], 1);
        @(posedge clk); #1; chk("spaced z_pulse width", 0, int'(zp_w[0]), 0);
        repeat (10) @(posedge clk);
        #1; chk("spaced z_level held", 0, int'(zl_w[0]), 1);
        pulse(1'b1, 1'b0);
        chk("spaced z_level drop", 0, int'(zl_w[0]), 0);

        // Counter saturation on CNT_W=2, then clr leaves z_level alone
        do_reset();
        repeat (5) begin
            pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); pulse(1'b0, 1'b1);
        end
        chk("sat match_cnt", 4, act_cnt[4], 3);
        chk("sat wide match_cnt", 0, act_cnt[0], 5);
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        chk("clr match_cnt", 4, act_cnt[4], 0);
        chk("clr wide match_cnt", 0, act_cnt[0], 0);
        chk("clr z_level", 4, int'(zl_w[4]), 1);
        @(negedge clk); clr = 1'b0;

        // Random phase; every cycle is compared against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            x1  = ($urandom_range(0, 2) == 0);
            x2  = ($urandom_range(0, 2) == 0);
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 249) == 0);
        end
        @(negedge clk);
        x1 = 1'b0; x2 = 1'b0; en = 1'b1; clr = 1'b0; rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
